// File: rtl/led_scan_ctrl_pkg.sv
// Shared widths and helpers for the LED scan controller.
// Position index width feeds the external 3-to-8 decoder directly.
package led_scan_ctrl_pkg;

    localparam int SCAN_POS_W = 3;
    localparam int SCAN_NPOS  = 8;
    localparam int NIBBLE_W   = 4;
    localparam int FRAME_W    = 32;

    typedef logic [SCAN_POS_W-1:0] pos_t;
    typedef logic [NIBBLE_W-1:0]   nibble_t;
    typedef logic [FRAME_W-1:0]    frame_t;

    function automatic nibble_t get_nibble(input frame_t frame, input pos_t pos);
        return frame[pos*NIBBLE_W +: NIBBLE_W];
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts CLK_DIV cycles per digit slot while enabled,
// flags the last cycle of a slot and the leading blanking window.
module scan_tick_gen #(
    parameter int CLK_DIV   = 1000,
    parameter int DIV_W     = 10,
    parameter int BLANK_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick,
    output logic in_blank
);

    localparam logic [DIV_W-1:0] CNT_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Holding the count while disabled lets a resumed slot finish its remaining cycles.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
        in_blank = (cnt_q < BLANK_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed 8-position display scanner with a double-buffered frame,
// per-slot anti-ghosting blank and a frame-done pulse.
module led_scan_ctrl
    import led_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 1000,
    parameter int DIV_W     = 10,
    parameter int BLANK_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [SCAN_POS_W-1:0] num_digits,
    input  logic                  load,
    input  logic [FRAME_W-1:0]    load_data,
    output logic [SCAN_POS_W-1:0] sel,
    output logic [NIBBLE_W-1:0]   digit,
    output logic                  blank,
    output logic                  frame_done
);

    logic tick;
    logic in_blank;

    pos_t   sel_q, sel_d;
    pos_t   last_q, last_d;
    frame_t active_q, active_d;
    frame_t pending_q, pending_d;
    logic   pending_valid_q, pending_valid_d;
    logic   frame_done_q, frame_done_d;

    scan_tick_gen #(
        .CLK_DIV  (CLK_DIV),
        .DIV_W    (DIV_W),
        .BLANK_CYC(BLANK_CYC)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .tick    (tick),
        .in_blank(in_blank)
    );

    // The buffer swap happens before the load update so a load landing on the
    // boundary cycle is held back for the following frame.
    always_comb begin
        sel_d           = sel_q;
        last_d          = last_q;
        active_d        = active_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        frame_done_d    = 1'b0;

        if (tick) begin
            if (sel_q == last_q) begin
                sel_d        = '0;
                last_d       = num_digits;
                frame_done_d = 1'b1;
                if (pending_valid_q) begin
                    active_d        = pending_q;
                    pending_valid_d = 1'b0;
                end
            end else begin
                sel_d = sel_q + SCAN_POS_W'(1);
            end
        end

        if (load) begin
            pending_d       = load_data;
            pending_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q           <= '0;
            last_q          <= SCAN_POS_W'(SCAN_NPOS - 1);
            active_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            sel_q           <= sel_d;
            last_q          <= last_d;
            active_q        <= active_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign sel        = sel_q;
    assign digit      = get_nibble(active_q, sel_q);
    assign blank      = ~en | in_blank;
    assign frame_done = frame_done_q;

endmodule
